dff_delay_line: RTL and testbench

- Parametrised successor to the single-bit clock-enabled DFF: a WIDTH-bit, DEPTH-stage enabled shift register with per-stage valid bits.
- Adds synchronous reset, flush and a runtime-selectable output tap.
- Occupancy is tracked by a registered counter.
- Used for balancing pipeline latency between datapaths and for delaying strobes alongside data.

---
 rtl/dff_delay_line.sv | 108 ++++++++++
 tb/tb_dff_delay_line.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dff_delay_line.sv
// dff_delay_line: WIDTH-bit, DEPTH-stage enabled delay line with per-stage
// valid bits, synchronous reset, flush, runtime output tap and a registered
// occupancy counter.
// Optional feature: define DFF_DELAY_LINE_TAPS_EN to expose every stage on
// taps/taps_vld; without it those ports do not exist.

// One register stage: data moves on en only, valid is also cleared by flush.
module dff_delay_stage #(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_vld,
  output logic [WIDTH-1:0] q,
  output logic             q_vld
);

  // rst > flush > en; flush drops valid but lets data keep shifting
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= RST_VAL;
      q_vld <= 1'b0;
    end else begin
      if (en) q <= d;
      if (flush)   q_vld <= 1'b0;
      else if (en) q_vld <= d_vld;
    end
  end

endmodule

module dff_delay_line #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int              SELW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int              CNTW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_vld,
  input  logic [SELW-1:0]  sel,
  output logic [WIDTH-1:0] q,
  output logic             q_vld,
  output logic [CNTW-1:0]  cnt
`ifdef DFF_DELAY_LINE_TAPS_EN
  ,
  output logic [DEPTH*WIDTH-1:0] taps,
  output logic [DEPTH-1:0]       taps_vld
`endif
);

  localparam logic [SELW-1:0] LAST = SELW'(DEPTH - 1);

  logic [DEPTH-1:0][WIDTH-1:0] stage_d, stage_q;
  logic [DEPTH-1:0]            vld_in, vld_pipe;
  logic [SELW-1:0]             tap;

  assign stage_d[0] = d;
  assign vld_in[0]  = d_vld;

  for (genvar i = 1; i < DEPTH; i++) begin : g_link
    assign stage_d[i] = stage_q[i-1];
    assign vld_in[i]  = vld_pipe[i-1];
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    dff_delay_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .flush (flush),
      .d     (stage_d[i]),
      .d_vld (vld_in[i]),
      .q     (stage_q[i]),
      .q_vld (vld_pipe[i])
    );
  end

  // occupancy: one in at the head, one out at the tail; modulo arithmetic
  // keeps the transient cnt+1 at cnt==DEPTH harmless
  always_ff @(posedge clk) begin
    if (rst || flush) cnt <= '0;
    else if (en)      cnt <= cnt + CNTW'(d_vld) - CNTW'(vld_pipe[DEPTH-1]);
  end

  // out-of-range selects (non power-of-2 DEPTH) clamp to the last stage
  always_comb begin
    tap = sel;
    if (sel > LAST) tap = LAST;
  end

  assign q     = stage_q[tap];
  assign q_vld = vld_pipe[tap];

`ifdef DFF_DELAY_LINE_TAPS_EN
  assign taps     = stage_q;
  assign taps_vld = vld_pipe;
`endif

endmodule

// File: tb/tb_dff_delay_line.sv
// Randomised + directed bench for dff_delay_line. A DEPTH=4 and a DEPTH=3
// instance share all inputs; the reference is a history queue of enabled
// inputs (newest first) from which every stage, tap and count is derived.
module tb_dff_delay_line;

  localparam logic [7:0] RV = 8'hA5;

  logic       clk = 1'b0;
  logic       rst, en, flush, d_vld;
  logic [7:0] d;
  logic [1:0] sel;
  logic [7:0] q1, q2;
  logic       qv1, qv2;
  logic [2:0] cnt1;
  logic [1:0] cnt2;
`ifdef DFF_DELAY_LINE_TAPS_EN
  logic [31:0] taps1;
  logic [3:0]  tv1;
  logic [23:0] taps2;
  logic [2:0]  tv2;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dff_delay_line #(.WIDTH(8), .DEPTH(4), .RST_VAL(RV)) dut4 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_vld(d_vld),
    .sel(sel), .q(q1), .q_vld(qv1), .cnt(cnt1)
`ifdef DFF_DELAY_LINE_TAPS_EN
    , .taps(taps1), .taps_vld(tv1)
`endif
  );

  dff_delay_line #(.WIDTH(8), .DEPTH(3), .RST_VAL(RV)) dut3 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_vld(d_vld),
    .sel(sel), .q(q2), .q_vld(qv2), .cnt(cnt2)
`ifdef DFF_DELAY_LINE_TAPS_EN
    , .taps(taps2), .taps_vld(tv2)
`endif
  );

  typedef struct packed { logic [7:0] d; logic v; } ent_t;
  ent_t hist[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic ent_t ent(input int i);
    ent_t e;
    e = '{RV, 1'b0};
    if (i < hist.size()) e = hist[i];
    return e;
  endfunction

  function automatic int pop(input int depth);
    int n = 0;
    for (int i = 0; i < depth && i < hist.size(); i++) n += int'(hist[i].v);
    return n;
  endfunction

  function automatic void model_clk(input logic r, input logic e, input logic f,
                                    input logic [7:0] dd, input logic dv);
    if (r) hist.delete();
    else if (f) begin
      foreach (hist[i]) hist[i].v = 1'b0;
      if (e) hist.push_front('{dd, 1'b0});
    end else if (e) hist.push_front('{dd, dv});
    while (hist.size() > 8) void'(hist.pop_back());
  endfunction

  task automatic check_all();
    int t4, t3;
    ent_t e4, e3;
    t4 = (int'(sel) > 3) ? 3 : int'(sel);
    t3 = (int'(sel) > 2) ? 2 : int'(sel);
    e4 = ent(t4);
    e3 = ent(t3);
    chk("q_d4",    q1,   e4.d);
    chk("qv_d4",   qv1,  e4.v);
    chk("cnt_d4",  cnt1, pop(4));
    chk("cnt_le4", cnt1 <= 3'd4, 1);
    chk("q_d3",    q2,   e3.d);
    chk("qv_d3",   qv2,  e3.v);
    chk("cnt_d3",  cnt2, pop(3));
`ifdef DFF_DELAY_LINE_TAPS_EN
    e4 = ent(1);
    chk("taps1_d4", taps1[15:8], e4.d);
    chk("tvld_d4",  tv1, {ent(3).v, ent(2).v, ent(1).v, ent(0).v});
    chk("tvld_d3",  tv2, {ent(2).v, ent(1).v, ent(0).v});
    chk("pop_d4",   cnt1, $countones(tv1));
    chk("pop_d3",   cnt2, $countones(tv2));
`endif
  endtask

  task automatic step(input logic r, input logic e, input logic f,
                      input logic [7:0] dd, input logic dv);
    rst = r; en = e; flush = f; d = dd; d_vld = dv;
    @(posedge clk);
    model_clk(r, e, f, dd, dv);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; d = '0; d_vld = 1'b0; sel = '0;

    // reset after some garbage traffic
    step(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'($urandom), 1'($urandom));
    step(1, 1, 1, 8'h5A, 1);
    chk("rst_q", q1, 8'hA5);
    chk("rst_qv", qv1, 0);
    chk("rst_cnt", cnt1, 0);

    // latency: sel=2 -> 3 enabled clocks
    sel = 2'd2;
    step(0, 1, 0, 8'h11, 1);
    chk("lat_cnt1", cnt1, 1);
    step(0, 1, 0, 8'($urandom), 0);
    chk("lat_qv_early", qv1, 0);
    step(0, 1, 0, 8'($urandom), 0);
    chk("lat_q", q1, 8'h11);
    chk("lat_qv", qv1, 1);
    step(0, 1, 0, 8'($urandom), 0);
    chk("lat_qv_late", qv1, 0);
    chk("lat_cnt4", cnt1, 1);
    step(0, 1, 0, 8'($urandom), 0);
    chk("lat_cnt0", cnt1, 0);

    // enable stall mid-flight
    sel = 2'd3;
    step(0, 1, 0, 8'h22, 1);
    step(0, 1, 0, 8'($urandom), 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 8'($urandom), 1'($urandom));
    chk("stall_cnt", cnt1, 1);
    step(0, 1, 0, 8'($urandom), 0);
    chk("stall_qv_early", qv1, 0);
    step(0, 1, 0, 8'($urandom), 0);
    chk("stall_q", q1, 8'h22);
    chk("stall_qv", qv1, 1);

    // full / wrap
    step(1, 0, 0, 8'h00, 0);
    for (int k = 1; k <= 6; k++) begin
      step(0, 1, 0, 8'(k), 1);
      chk("full_cnt", cnt1, (k > 4) ? 4 : k);
      if (k >= 4) chk("full_q", q1, 8'(k - 3));
    end
    for (int k = 3; k >= 0; k--) begin
      step(0, 1, 0, 8'($urandom), 0);
      chk("drain_cnt", cnt1, k);
    end

    // flush with en and d_vld high
    for (int k = 0; k < 3; k++) step(0, 1, 0, 8'(8'h30 + k), 1);
    step(0, 1, 1, 8'h77, 1);
    chk("flush_cnt", cnt1, 0);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk("flush_qv", qv1, 0);
      chk("flush_qv3", qv2, 0);
    end
    sel = 2'd0;
    #1;
    chk("flush_q0", q1, 8'h77);
    step(1, 1, 1, 8'h99, 1);
    chk("rstflush_q", q1, 8'hA5);
    sel = 2'd3;
    #1;
    chk("rstflush_q3", q2, 8'hA5);

    // randomised traffic, including DEPTH=3 clamp for sel=3
    for (int i = 0; i < 400; i++) begin
      sel = 2'($urandom);
      step(1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 75),
           1'($urandom_range(0, 99) < 5), 8'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
